// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - eight-entry register file with pending-write scoreboard
//
// Purpose: holds r1..r7 (r0 reads as zero), tracks outstanding writebacks per
// register, and gates instruction issue on RAW/WAW hazards.
// Writeback data and hazard clearing are forwarded in the same cycle.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ra_sel, rb_sel    read port indices; ra_data, rb_data combinational operands
//   issue_valid/uses_a/uses_b/wr/dst  decoded instruction; issue_ready combinational
//   wb_en, wb_sel, wb_data            writeback strobe, index, value
//   pending           registered scoreboard bits
//   wb_err            sticky writeback-to-non-pending flag
module regfile_scoreboard #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ra_sel,
  input  logic [2:0]       rb_sel,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  input  logic             issue_valid,
  input  logic             issue_uses_a,
  input  logic             issue_uses_b,
  input  logic             issue_wr,
  input  logic [2:0]       issue_dst,
  output logic             issue_ready,
  input  logic             wb_en,
  input  logic [2:0]       wb_sel,
  input  logic [WIDTH-1:0] wb_data,
  output logic [7:0]       pending,
  output logic             wb_err
);

  // Entry 0 is never written, so it stays at its reset value of zero.
  logic [WIDTH-1:0] r_regs [8];
  logic [7:0]       r_pending;
  logic             r_wb_err;

  logic [7:0]       w_wb_onehot;
  logic [7:0]       w_issue_onehot;
  logic [7:0]       w_epend;
  logic             w_issue_fire;
  logic [7:0]       w_pending_next;

  assign w_wb_onehot    = wb_en ? (8'b1 << wb_sel) : 8'b0;
  assign w_issue_onehot = 8'b1 << issue_dst;

  // A writeback landing this cycle already resolves the hazard on its index.
  assign w_epend = r_pending & ~w_wb_onehot;

  assign issue_ready = !(issue_uses_a && w_epend[ra_sel]) &&
                       !(issue_uses_b && w_epend[rb_sel]) &&
                       !(issue_wr     && w_epend[issue_dst]);

  assign w_issue_fire = issue_valid && issue_ready && issue_wr;

  // Clear from writeback first, then set from issue so a same-index issue wins.
  always_comb begin
    w_pending_next = r_pending & ~w_wb_onehot;
    if (w_issue_fire) begin
      w_pending_next = w_pending_next | w_issue_onehot;
    end
    w_pending_next[0] = 1'b0;
  end

  always_comb begin
    ra_data = r_regs[ra_sel];
    if (wb_en && (wb_sel == ra_sel) && (ra_sel != 3'd0)) begin
      ra_data = wb_data;
    end
  end

  always_comb begin
    rb_data = r_regs[rb_sel];
    if (wb_en && (wb_sel == rb_sel) && (rb_sel != 3'd0)) begin
      rb_data = wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en && (wb_sel != 3'd0)) begin
      r_regs[wb_sel] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= 8'h00;
      r_wb_err  <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (wb_en && (wb_sel != 3'd0) && !r_pending[wb_sel]) begin
        r_wb_err <= 1'b1;
      end
    end
  end

  assign pending = r_pending;
  assign wb_err  = r_wb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  ra_sel, rb_sel;
  logic [31:0] ra_data, rb_data;
  logic        issue_valid, issue_uses_a, issue_uses_b, issue_wr;
  logic [2:0]  issue_dst;
  logic        issue_ready;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [31:0] wb_data;
  logic [7:0]  pending;
  logic        wb_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_reg [8];
  bit          m_pend [8];
  bit          m_err;

  regfile_scoreboard #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .ra_sel(ra_sel), .rb_sel(rb_sel), .ra_data(ra_data), .rb_data(rb_data),
    .issue_valid(issue_valid), .issue_uses_a(issue_uses_a), .issue_uses_b(issue_uses_b),
    .issue_wr(issue_wr), .issue_dst(issue_dst), .issue_ready(issue_ready),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .pending(pending), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy(input int n);
    return m_pend[n] && !(wb_en && (int'(wb_sel) == n));
  endfunction

  function automatic bit m_ready();
    bit hz = 0;
    if (issue_uses_a && m_busy(int'(ra_sel))) hz = 1;
    if (issue_uses_b && m_busy(int'(rb_sel))) hz = 1;
    if (issue_wr && m_busy(int'(issue_dst))) hz = 1;
    return !hz;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] sel);
    if (sel == 0) return 32'h0;
    if (wb_en && wb_sel == sel) return wb_data;
    return m_reg[sel];
  endfunction

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_reg[i]  = 32'h0;
      m_pend[i] = 0;
    end
    m_err = 0;
  endtask

  task automatic idle();
    ra_sel = 0; rb_sel = 0;
    issue_valid = 0; issue_uses_a = 0; issue_uses_b = 0; issue_wr = 0; issue_dst = 0;
    wb_en = 0; wb_sel = 0; wb_data = 0;
  endtask

  // Advance one clock edge, applying the spec's update rules to the model.
  task automatic tick();
    bit fire;
    fire = issue_valid && m_ready() && issue_wr;
    @(posedge clk);
    if (wb_en) begin
      if (wb_sel != 0) begin
        if (!m_pend[wb_sel]) m_err = 1;
        m_reg[wb_sel] = wb_data;
      end
      m_pend[wb_sel] = 0;
    end
    if (fire && issue_dst != 0) m_pend[issue_dst] = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    model_clear();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 1; s < 8; s++) begin
      ra_sel = 3'(s); rb_sel = 3'(8 - s);
      #1;
      total++;
      if (ra_data !== 32'h0 || rb_data !== 32'h0) begin
        bad++;
        $display("FAIL reset_read sel=%0d ra=%h rb=%h required 0", s, ra_data, rb_data);
      end
    end
    total++;
    if (pending !== 8'h00 || issue_ready !== 1'b1 || wb_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state pending=%h ready=%b err=%b required 00/1/0", pending, issue_ready, wb_err);
    end
    @(negedge clk);
  endtask

  task automatic test_basic_hazard();
    idle();
    issue_valid = 1; issue_wr = 1; issue_dst = 3;
    tick();
    idle();
    total++;
    if (pending !== 8'h08) begin
      bad++; $display("FAIL hazard_pend actual=%h required=08", pending);
    end
    issue_valid = 1; issue_uses_a = 1; ra_sel = 3;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (issue_ready !== 1'b0) begin
        bad++; $display("FAIL hazard_stall cycle=%0d actual=%b required=0", k, issue_ready);
      end
      tick();
    end
    wb_en = 1; wb_sel = 3; wb_data = 32'hDEADBEEF;
    #1;
    total++;
    if (ra_data !== 32'hDEADBEEF || issue_ready !== 1'b1) begin
      bad++; $display("FAIL hazard_bypass ra=%h ready=%b required deadbeef/1", ra_data, issue_ready);
    end
    tick();
    idle(); ra_sel = 3;
    #1;
    total++;
    if (pending !== 8'h00 || ra_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL hazard_retire pending=%h ra=%h required 00/deadbeef", pending, ra_data);
    end
  endtask

  task automatic test_collision();
    idle();
    issue_valid = 1; issue_wr = 1; issue_dst = 5;
    tick();
    wb_en = 1; wb_sel = 5; wb_data = 32'h1234;
    #1;
    total++;
    if (issue_ready !== 1'b1) begin
      bad++; $display("FAIL collide_ready actual=%b required=1", issue_ready);
    end
    tick();
    idle(); ra_sel = 5;
    #1;
    total++;
    if (pending !== 8'h20 || ra_data !== 32'h1234 || wb_err !== 1'b0) begin
      bad++; $display("FAIL collide_state pending=%h r5=%h err=%b required 20/1234/0", pending, ra_data, wb_err);
    end
    wb_en = 1; wb_sel = 5; wb_data = 32'h5678;
    tick();
    idle();
  endtask

  task automatic test_r0_errors();
    idle();
    issue_valid = 1; issue_wr = 1; issue_dst = 0;
    tick();
    idle();
    total++;
    if (pending !== 8'h00) begin
      bad++; $display("FAIL r0_pend actual=%h required=00", pending);
    end
    wb_en = 1; wb_sel = 0; wb_data = 32'hFFFFFFFF; ra_sel = 0; rb_sel = 0;
    #1;
    total++;
    if (ra_data !== 32'h0 || rb_data !== 32'h0) begin
      bad++; $display("FAIL r0_bypass ra=%h rb=%h required 0", ra_data, rb_data);
    end
    tick();
    idle();
    #1;
    total++;
    if (ra_data !== 32'h0 || wb_err !== 1'b0) begin
      bad++; $display("FAIL r0_write ra=%h err=%b required 0/0", ra_data, wb_err);
    end
    wb_en = 1; wb_sel = 6; wb_data = 32'hA5A5_0606;
    tick();
    idle(); ra_sel = 6;
    #1;
    total++;
    if (wb_err !== 1'b1 || ra_data !== 32'hA5A5_0606) begin
      bad++; $display("FAIL err_set err=%b r6=%h required 1/a5a50606", wb_err, ra_data);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (wb_err !== 1'b1) begin
        bad++; $display("FAIL err_sticky cycle=%0d actual=%b required=1", k, wb_err);
      end
    end
  endtask

  task automatic test_waw_reset();
    idle();
    issue_valid = 1; issue_wr = 1; issue_dst = 2;
    tick();
    issue_dst = 7;
    tick();
    #1;
    total++;
    if (pending !== 8'h84 || issue_ready !== 1'b0) begin
      bad++; $display("FAIL waw pending=%h ready=%b required 84/0", pending, issue_ready);
    end
    ra_sel = 6; rb_sel = 6;
    #1;
    reset = 1;
    model_clear();
    #1;
    total++;
    if (pending !== 8'h00 || wb_err !== 1'b0 || ra_data !== 32'h0 || rb_data !== 32'h0 || issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset pending=%h err=%b ra=%h rb=%h ready=%b required 00/0/0/0/1",
               pending, wb_err, ra_data, rb_data, issue_ready);
    end
    @(negedge clk);
    reset = 0;
    idle();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] pv;
    for (int c = 0; c < 400; c++) begin
      ra_sel = 3'($urandom_range(0, 7));
      rb_sel = 3'($urandom_range(0, 7));
      issue_valid  = 1'($urandom_range(0, 1));
      issue_uses_a = 1'($urandom_range(0, 1));
      issue_uses_b = 1'($urandom_range(0, 1));
      issue_wr     = 1'($urandom_range(0, 1));
      issue_dst    = 3'($urandom_range(0, 7));
      wb_en        = ($urandom_range(0, 2) != 0);
      wb_sel       = 3'($urandom_range(0, 7));
      // Bias writebacks toward registers that are actually pending.
      for (int t = 0; t < 4; t++) begin
        if (!m_pend[wb_sel]) wb_sel = 3'($urandom_range(0, 7));
      end
      wb_data = $urandom;
      #1;
      total++;
      if (ra_data !== m_read(ra_sel) || rb_data !== m_read(rb_sel) || issue_ready !== m_ready()) begin
        bad++;
        $display("FAIL rand_comb cyc=%0d ra=%h/%h rb=%h/%h ready=%b/%b (actual/required)",
                 c, ra_data, m_read(ra_sel), rb_data, m_read(rb_sel), issue_ready, m_ready());
      end
      tick();
      pv = m_pend_vec();
      total++;
      if (pending !== pv || wb_err !== m_err) begin
        bad++;
        $display("FAIL rand_state cyc=%0d pending=%h/%h err=%b/%b (actual/required)",
                 c, pending, pv, wb_err, m_err);
      end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    model_clear();
    test_reset();
    test_basic_hazard();
    test_collision();
    test_r0_errors();
    test_waw_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
